// File: rtl/demux_pkg.sv
// Shared constants and helpers for the buffered 1:2 word demultiplexer.
package demux_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int STATS_W    = 16;

    // Same select convention as the 2:1 mux: a low select means output A.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO with registered head output; full/empty derive from level.
module demux_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // A full FIFO refuses a push even when it pops in the same cycle.
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/demux1x2_32_buf.sv
// Buffered 1:2 demux: steers each accepted word into FIFO A or B by in_sel.
// Define DEMUX1X2_STATS_EN to add saturating per-output push counters a_cnt/b_cnt.
module demux1x2_32_buf
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_sel,
    output logic                     a_valid,
    input  logic                     a_ready,
    output logic [DATA_W-1:0]        a_data,
    output logic                     b_valid,
    input  logic                     b_ready,
    output logic [DATA_W-1:0]        b_data,
    output logic [$clog2(DEPTH):0]   a_level,
    output logic [$clog2(DEPTH):0]   b_level
`ifdef DEMUX1X2_STATS_EN
    ,
    output logic [STATS_W-1:0]       a_cnt,
    output logic [STATS_W-1:0]       b_cnt
`endif
);

    logic a_full;
    logic b_full;
    logic a_empty;
    logic b_empty;
    logic push_a;
    logic push_b;

    // Readiness looks only at the selected FIFO, so a stalled consumer
    // never blocks words headed for the other output.
    assign in_ready = (in_sel == SEL_B) ? !b_full : !a_full;
    assign push_a   = in_valid && in_ready && (in_sel == SEL_A);
    assign push_b   = in_valid && in_ready && (in_sel == SEL_B);
    assign a_valid  = !a_empty;
    assign b_valid  = !b_empty;

    demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .pop       (a_ready),
        .head      (a_data),
        .full      (a_full),
        .empty     (a_empty),
        .level     (a_level)
    );

    demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .pop       (b_ready),
        .head      (b_data),
        .full      (b_full),
        .empty     (b_empty),
        .level     (b_level)
    );

`ifdef DEMUX1X2_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (push_a) begin
                a_cnt <= sat_inc(a_cnt);
            end
            if (push_b) begin
                b_cnt <= sat_inc(b_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux1x2_32_buf.sv
// Scoreboard bench for demux1x2_32_buf: issued words queue per output, a monitor checks deliveries.
module tb_demux1x2_32_buf;
    import demux_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sel;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_data;
    logic [1:0]  a_level;
    logic [1:0]  b_level;
`ifdef DEMUX1X2_STATS_EN
    logic [15:0] a_cnt;
    logic [15:0] b_cnt;
`endif

    logic [31:0] expA[$];
    logic [31:0] expB[$];
    int vectors     = 0;
    int miscompares = 0;

    demux1x2_32_buf #(.DATA_W(32), .DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_level  (a_level),
        .b_level  (b_level)
`ifdef DEMUX1X2_STATS_EN
        ,
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record every word the DUT will accept at the coming edge.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            if (in_sel == SEL_A) expA.push_back(in_data);
            else                 expB.push_back(in_data);
        end
    end

    // Check every word a consumer takes against the oldest expected word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid && a_ready) begin
                if (expA.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL a_unexpected: got %h expected no word", a_data);
                end else begin
                    checkOutput("a_data", a_data, expA.pop_front());
                end
            end
            if (b_valid && b_ready) begin
                if (expB.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL b_unexpected: got %h expected no word", b_data);
                end else begin
                    checkOutput("b_data", b_data, expB.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        applyStimulus(1'b0, SEL_A, 32'h0);

        // Reset then idle
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_a_valid",  32'(a_valid),  32'd0);
        checkOutput("rst_b_valid",  32'(b_valid),  32'd0);
        checkOutput("rst_a_level",  32'(a_level),  32'd0);
        checkOutput("rst_b_level",  32'(b_level),  32'd0);
        tick();

        // Single push to each side on consecutive cycles
        a_ready = 1'b1;
        b_ready = 1'b1;
        applyStimulus(1'b1, SEL_A, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b1, SEL_B, 32'h12345678);
        @(negedge clk);
        checkOutput("single_a_valid", 32'(a_valid), 32'd1);
        checkOutput("single_a_data",  a_data,       32'hDEADBEEF);
        checkOutput("single_b_idle",  32'(b_valid), 32'd0);
        tick();
        applyStimulus(1'b0, SEL_A, 32'h0);
        @(negedge clk);
        checkOutput("single_b_valid", 32'(b_valid), 32'd1);
        checkOutput("single_b_data",  b_data,       32'h12345678);
        checkOutput("single_a_idle",  32'(a_valid), 32'd0);
        tick();

        // Backpressure on B must not block A
        b_ready = 1'b0;
        applyStimulus(1'b1, SEL_B, 32'h11110001);
        tick();
        applyStimulus(1'b1, SEL_B, 32'h11110002);
        tick();
        applyStimulus(1'b1, SEL_B, 32'h11110003);
        @(negedge clk);
        checkOutput("bp_b_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_b_level",    32'(b_level),  32'd2);
        tick();
        applyStimulus(1'b1, SEL_A, 32'hAAAA0001);
        @(negedge clk);
        checkOutput("bp_a_in_ready", 32'(in_ready), 32'd1);
        tick();
        applyStimulus(1'b0, SEL_A, 32'h0);
        @(negedge clk);
        checkOutput("bp_a_valid",   32'(a_valid), 32'd1);
        checkOutput("bp_a_data",    a_data,       32'hAAAA0001);
        checkOutput("bp_b_level_2", 32'(b_level), 32'd2);
        tick();
        b_ready = 1'b1;
        repeat (3) tick();

        // Full FIFO refuses a push even while popping
        a_ready = 1'b0;
        applyStimulus(1'b1, SEL_A, 32'h00000001);
        tick();
        applyStimulus(1'b1, SEL_A, 32'h00000002);
        tick();
        a_ready = 1'b1;
        applyStimulus(1'b1, SEL_A, 32'h00000003);
        @(negedge clk);
        checkOutput("full_a_level",    32'(a_level),  32'd2);
        checkOutput("full_in_ready",   32'(in_ready), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("full_in_ready_2", 32'(in_ready), 32'd1);
        tick();
        applyStimulus(1'b0, SEL_A, 32'h0);
        repeat (3) tick();

        // Reset mid-operation discards buffered words
        a_ready = 1'b0;
        b_ready = 1'b0;
        applyStimulus(1'b1, SEL_A, 32'hC0000001);
        tick();
        applyStimulus(1'b1, SEL_A, 32'hC0000002);
        tick();
        applyStimulus(1'b1, SEL_B, 32'hD0000001);
        tick();
        applyStimulus(1'b1, SEL_B, 32'hD0000002);
        tick();
        applyStimulus(1'b0, SEL_A, 32'h0);
        @(negedge clk);
        checkOutput("pre_rst_a_level", 32'(a_level), 32'd2);
        checkOutput("pre_rst_b_level", 32'(b_level), 32'd2);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        expA.delete();
        expB.delete();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_a_valid", 32'(a_valid), 32'd0);
        checkOutput("mid_rst_b_valid", 32'(b_valid), 32'd0);
        checkOutput("mid_rst_a_level", 32'(a_level), 32'd0);
        checkOutput("mid_rst_b_level", 32'(b_level), 32'd0);
        a_ready = 1'b1;
        b_ready = 1'b1;
        repeat (3) tick();
        applyStimulus(1'b1, SEL_A, 32'hE0000001);
        tick();
        applyStimulus(1'b1, SEL_B, 32'hE0000002);
        tick();
        applyStimulus(1'b0, SEL_A, 32'h0);
        repeat (3) tick();

`ifdef DEMUX1X2_STATS_EN
        // Push counters: exact counts, then saturation
        rst_n = 1'b0;
        @(negedge clk);
        expA.delete();
        expB.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, SEL_A, 32'h50000000 + 32'(i));
            tick();
        end
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, SEL_B, 32'h70000000 + 32'(i));
            tick();
        end
        applyStimulus(1'b0, SEL_A, 32'h0);
        @(negedge clk);
        checkOutput("stats_a_cnt", 32'(a_cnt), 32'd5);
        checkOutput("stats_b_cnt", 32'(b_cnt), 32'd7);
        tick();
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(1'b1, SEL_A, 32'(i));
            tick();
        end
        applyStimulus(1'b0, SEL_A, 32'h0);
        @(negedge clk);
        checkOutput("stats_a_sat", 32'(a_cnt), 32'h0000FFFF);
        checkOutput("stats_b_hold", 32'(b_cnt), 32'd7);
        tick();
`endif

        // Drain: every issued word must have been delivered
        a_ready = 1'b1;
        b_ready = 1'b1;
        applyStimulus(1'b0, SEL_A, 32'h0);
        for (int i = 0; i < 20 && (expA.size() != 0 || expB.size() != 0); i++) begin
            tick();
        end
        checkOutput("drain_a", 32'(expA.size()), 32'd0);
        checkOutput("drain_b", 32'(expB.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux1x2_32_buf.md
Name: demux1x2_32_buf

Overview:
- Buffered 1-to-2 demultiplexer for 32-bit words; the inverse of the 2:1 32-bit select path.
- Accepts one word per cycle on a valid/ready input channel and steers it by a select bit to output A (sel=0) or output B (sel=1).
- Each output has its own small FIFO, so a stalled consumer blocks only traffic selected toward it.
- Sits between the datapath result/store bus and two consumers, e.g. data memory and a memory-mapped I/O port.

Parameters:
- DATA_W, 32, word width.
- DEPTH, 2, entries per output FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  DATA_W  input word.
- in_sel  input  1  destination: 0 = output A, 1 = output B.
- a_valid  output  1  output A head word valid.
- a_ready  input  1  consumer A takes head word.
- a_data  output  DATA_W  output A head word.
- b_valid  output  1  output B head word valid.
- b_ready  input  1  consumer B takes head word.
- b_data  output  DATA_W  output B head word.
- a_level  output  $clog2(DEPTH)+1  entries held in FIFO A.
- b_level  output  $clog2(DEPTH)+1  entries held in FIFO B.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Both FIFOs empty; read/write pointers and levels cleared.
  - a_valid=b_valid=0, a_level=b_level=0, in_ready=1.
  - a_data/b_data are don't-care while valid=0.
  - Reset mid-stream discards all buffered words; no partial delivery afterwards.
- in_ready:
  - Combinational: in_ready = !full(FIFO selected by in_sel).
  - Does not depend on same-cycle a_ready/b_ready (no pass-through credit).
  - Depends on in_sel, so it may change while in_valid is held.
- Push: in_valid & in_ready at a rising edge writes in_data into the selected FIFO.
- Latency: the word is visible on x_valid/x_data the following cycle at the earliest; there is no combinational in-to-out path.
- Pop: x_valid & x_ready at a rising edge removes the head word. x_ready while x_valid=0 is ignored.
- Simultaneous push and pop on the same FIFO:
  - Allowed when not full.
  - Level unchanged; ordering preserved.
  - When empty, the pushed word appears next cycle.
- A full FIFO refuses pushes even if it pops in the same cycle.
- Simultaneous pop of A and B in one cycle is allowed.
- Ordering:
  - FIFO order is guaranteed within each output.
  - No ordering is guaranteed between A and B.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from level (level==DEPTH / level==0).
- Output stability: x_data and x_valid must not change while x_valid=1 & x_ready=0.
- Data path is transparent: no modification of the data word.

Optional Feature:
- Macro DEMUX1X2_STATS_EN.
- When defined, adds outputs a_cnt and b_cnt (16 bits each):
  - Each counts accepted pushes toward A or B.
  - Saturating at 16'hFFFF.
  - Cleared by reset.
  - Counting happens on the push edge.
- When undefined, these ports and registers are absent.
- Core behaviour is identical either way.

Decomposition:
- Package demux_pkg holds:
  - DATA_W default (32).
  - SEL_A=1'b0, SEL_B=1'b1 encodings, matching the mux convention (s=0 selects a).
  - STATS_W=16.
- One sub-module, demux_fifo:
  - Synchronous FIFO with push/pop/full/empty/level and head output, parameterised by DATA_W and DEPTH.
  - Instantiated twice (FIFO A, FIFO B).
- Top level contains only steering logic, in_ready generation and optional stats counters.

Test Plan:
- Reset then idle: after rst_n low for 2 cycles -> in_ready=1, a_valid=b_valid=0, levels 0.
- Single push: push 32'hDEADBEEF with sel=0 and 32'h12345678 with sel=1 on consecutive cycles, consumers ready.
  - Expect a_valid with DEADBEEF one cycle after its push.
  - Expect b_valid with 12345678 one cycle after its push.
  - The other output stays invalid.
- Backpressure isolation: b_ready=0, push 3 words sel=1.
  - Third word stalls with in_ready=0 and b_level=2.
  - A push with sel=0 in the same interval is accepted and delivered.
- Full with simultaneous pop: FIFO A full (DEPTH=2), a_ready=1, in_valid=1, sel=0.
  - in_ready=0 that cycle.
  - Accepted next cycle; order 1,2,3 preserved on a_data.
- Reset mid-operation: both FIFOs holding 2 words, assert rst_n=0 one cycle.
  - Both valids 0 and levels 0 next cycle.
  - Pre-reset words never appear.
- Stats (DEMUX1X2_STATS_EN): 5 pushes to A, 7 to B -> a_cnt=5, b_cnt=7; forced count at 16'hFFFF plus one push stays at FFFF.
